// File: rtl/cmp_pipe_unit.sv
// Two-stage pipelined signed/unsigned comparator with valid/ready handshake,
// running min/max tracking of MIN/MAX results and a saturating true-result counter.
module cmp_pipe_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       cmp_op,
    input  logic             cmp_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cmp_flag,
    output logic [1:0]       cmp_code,
    output logic [WIDTH-1:0] cmp_val,
    input  logic             trk_clr,
    output logic             trk_valid,
    output logic [WIDTH-1:0] trk_min,
    output logic [WIDTH-1:0] trk_max,
    output logic [CNT_W-1:0] true_cnt
);

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_EQ  = 3'b001,
        OP_GT  = 3'b010,
        OP_LT  = 3'b011,
        OP_GE  = 3'b100,
        OP_LE  = 3'b101,
        OP_MIN = 3'b110,
        OP_MAX = 3'b111
    } cmpOp_t;

    localparam logic [1:0]       CODE_NONE = 2'b00;
    localparam logic [1:0]       CODE_EQ   = 2'b01;
    localparam logic [1:0]       CODE_GT   = 2'b10;
    localparam logic [1:0]       CODE_LT   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    cmpOp_t           r_s1Op;
    logic             r_s1Signed;

    logic             r_s2Valid;
    cmpOp_t           r_s2Op;
    logic             r_s2Signed;
    logic             r_flag;
    logic [1:0]       r_code;
    logic [WIDTH-1:0] r_val;

    logic             r_trkValid;
    logic [WIDTH-1:0] r_trkMin;
    logic [WIDTH-1:0] r_trkMax;
    logic [CNT_W-1:0] r_trueCnt;

    logic             w_s2Load;
    logic             w_accept;
    logic             w_retire;
    logic             w_isEq;
    logic             w_isGt;
    logic             w_isLt;
    logic             w_flag;
    logic [1:0]       w_code;
    logic [WIDTH-1:0] w_val;
    logic             w_valLtMin;
    logic             w_valGtMax;
    logic             w_isMinMax;

    // S2 can take a new result when empty or when its current result retires.
    assign w_s2Load = !r_s2Valid || out_ready;
    assign in_ready = !r_s1Valid || w_s2Load;
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_s2Valid && out_ready;

    always_comb begin
        w_isEq = (r_s1A == r_s1B);
        if (r_s1Signed) begin
            w_isGt = ($signed(r_s1A) > $signed(r_s1B));
        end else begin
            w_isGt = (r_s1A > r_s1B);
        end
        w_isLt = !w_isEq && !w_isGt;
    end

    always_comb begin
        w_flag = 1'b0;
        w_val  = '0;
        if (w_isEq) begin
            w_code = CODE_EQ;
        end else if (w_isGt) begin
            w_code = CODE_GT;
        end else begin
            w_code = CODE_LT;
        end
        case (r_s1Op)
            OP_NOP: w_code = CODE_NONE;
            OP_EQ:  w_flag = w_isEq;
            OP_GT:  w_flag = w_isGt;
            OP_LT:  w_flag = w_isLt;
            OP_GE:  w_flag = !w_isLt;
            OP_LE:  w_flag = !w_isGt;
            // Ties fall through to in_a for both MIN and MAX.
            OP_MIN: w_val  = w_isGt ? r_s1B : r_s1A;
            OP_MAX: w_val  = w_isLt ? r_s1B : r_s1A;
            default: w_flag = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid  <= 1'b0;
            r_s1A      <= '0;
            r_s1B      <= '0;
            r_s1Op     <= OP_NOP;
            r_s1Signed <= 1'b0;
        end else if (in_ready) begin
            r_s1Valid <= in_valid;
            if (w_accept) begin
                r_s1A      <= in_a;
                r_s1B      <= in_b;
                r_s1Op     <= cmpOp_t'(cmp_op);
                r_s1Signed <= cmp_signed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2Valid  <= 1'b0;
            r_s2Op     <= OP_NOP;
            r_s2Signed <= 1'b0;
            r_flag     <= 1'b0;
            r_code     <= CODE_NONE;
            r_val      <= '0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Op     <= r_s1Op;
                r_s2Signed <= r_s1Signed;
                r_flag     <= w_flag;
                r_code     <= w_code;
                r_val      <= w_val;
            end
        end
    end

    always_comb begin
        w_isMinMax = (r_s2Op == OP_MIN) || (r_s2Op == OP_MAX);
        if (r_s2Signed) begin
            w_valLtMin = ($signed(r_val) < $signed(r_trkMin));
            w_valGtMax = ($signed(r_val) > $signed(r_trkMax));
        end else begin
            w_valLtMin = (r_val < r_trkMin);
            w_valGtMax = (r_val > r_trkMax);
        end
    end

    // A clear coinciding with a retire treats that retire as the first sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trkValid <= 1'b0;
            r_trkMin   <= '0;
            r_trkMax   <= '0;
            r_trueCnt  <= '0;
        end else begin
            if (w_retire && w_isMinMax) begin
                r_trkValid <= 1'b1;
                if (trk_clr || !r_trkValid) begin
                    r_trkMin <= r_val;
                    r_trkMax <= r_val;
                end else begin
                    if (w_valLtMin) begin
                        r_trkMin <= r_val;
                    end
                    if (w_valGtMax) begin
                        r_trkMax <= r_val;
                    end
                end
            end else if (trk_clr) begin
                r_trkValid <= 1'b0;
                r_trkMin   <= '0;
                r_trkMax   <= '0;
            end

            if (trk_clr) begin
                r_trueCnt <= (w_retire && r_flag) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            end else if (w_retire && r_flag && (r_trueCnt != CNT_MAX)) begin
                r_trueCnt <= r_trueCnt + 1'b1;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign cmp_flag  = r_flag;
    assign cmp_code  = r_code;
    assign cmp_val   = r_val;
    assign trk_valid = r_trkValid;
    assign trk_min   = r_trkMin;
    assign trk_max   = r_trkMax;
    assign true_cnt  = r_trueCnt;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed, table-driven bench for cmp_pipe_unit: single transactions from a vector
// table plus hand-written streaming, backpressure, tracking-clear and reset sequences.
module tb_cmp_pipe_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    localparam logic [2:0] NOP = 3'b000, EQ = 3'b001, GT = 3'b010, LT = 3'b011;
    localparam logic [2:0] GE = 3'b100, LE = 3'b101, MIN = 3'b110, MAX = 3'b111;

    logic             clk;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [2:0]       cmpOp;
    logic             cmpSigned;
    logic             outValid;
    logic             outReady;
    logic             cmpFlag;
    logic [1:0]       cmpCode;
    logic [WIDTH-1:0] cmpVal;
    logic             trkClr;
    logic             trkValid;
    logic [WIDTH-1:0] trkMin;
    logic [WIDTH-1:0] trkMax;
    logic [CNT_W-1:0] trueCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]       op;
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             flag;
        logic [1:0]       code;
        logic [WIDTH-1:0] val;
    } vec_t;

    vec_t vecs[14];

    cmp_pipe_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .cmp_op     (cmpOp),
        .cmp_signed (cmpSigned),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .cmp_flag   (cmpFlag),
        .cmp_code   (cmpCode),
        .cmp_val    (cmpVal),
        .trk_clr    (trkClr),
        .trk_valid  (trkValid),
        .trk_min    (trkMin),
        .trk_max    (trkMax),
        .true_cnt   (trueCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic sgn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        inValid   = v;
        cmpOp     = op;
        cmpSigned = sgn;
        inA       = a;
        inB       = b;
    endtask

    // Issues one transaction at a negedge and returns at the negedge where out_valid shows.
    task automatic applyStimulus(input logic [2:0] op, input logic sgn,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int lat);
        lat = -1;
        @(negedge clk);
        drive(1'b1, op, sgn, a, b);
        @(negedge clk);
        drive(1'b0, NOP, 1'b0, '0, '0);
        for (int c = 1; c <= 10; c++) begin
            if (outValid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    int           lat;
    int           expCnt;
    int           leaks;
    logic [15:0]  streamA[3];
    logic [2:0]   streamOp[3];
    logic [15:0]  streamExp[3];
    logic [15:0]  rxQ[$];

    initial begin
        vecs[0]  = '{EQ,  1'b0, 16'h1234, 16'h1234, 1'b1, 2'b01, 16'h0000};
        vecs[1]  = '{GT,  1'b0, 16'hFFFF, 16'h0001, 1'b1, 2'b10, 16'h0000};
        vecs[2]  = '{GT,  1'b1, 16'hFFFF, 16'h0001, 1'b0, 2'b11, 16'h0000};
        vecs[3]  = '{LT,  1'b1, 16'h8000, 16'h7FFF, 1'b1, 2'b11, 16'h0000};
        vecs[4]  = '{LT,  1'b0, 16'h8000, 16'h7FFF, 1'b0, 2'b10, 16'h0000};
        vecs[5]  = '{GE,  1'b0, 16'h0005, 16'h0005, 1'b1, 2'b01, 16'h0000};
        vecs[6]  = '{LE,  1'b1, 16'h0003, 16'hFFFE, 1'b0, 2'b10, 16'h0000};
        vecs[7]  = '{MIN, 1'b1, 16'hFFFD, 16'h0005, 1'b0, 2'b11, 16'hFFFD};
        vecs[8]  = '{MAX, 1'b0, 16'hFFFD, 16'h0005, 1'b0, 2'b10, 16'hFFFD};
        vecs[9]  = '{MIN, 1'b0, 16'h0007, 16'h0007, 1'b0, 2'b01, 16'h0007};
        vecs[10] = '{NOP, 1'b0, 16'h1234, 16'h0000, 1'b0, 2'b00, 16'h0000};
        vecs[11] = '{MAX, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 2'b11, 16'h7FFF};
        vecs[12] = '{GE,  1'b1, 16'h8000, 16'h0000, 1'b0, 2'b11, 16'h0000};
        vecs[13] = '{LE,  1'b0, 16'h0001, 16'h0002, 1'b1, 2'b11, 16'h0000};

        rst      = 1'b0;
        outReady = 1'b1;
        trkClr   = 1'b0;
        drive(1'b0, NOP, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset true_cnt", 32'(trueCnt), 32'd0);
        checkOutput("reset trk_valid", 32'(trkValid), 32'd0);
        checkOutput("reset cmp_val", 32'(cmpVal), 32'd0);
        rst = 1'b1;

        expCnt = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("vec%0d flag", i), 32'(cmpFlag), 32'(vecs[i].flag));
            checkOutput($sformatf("vec%0d code", i), 32'(cmpCode), 32'(vecs[i].code));
            checkOutput($sformatf("vec%0d val", i), 32'(cmpVal), 32'(vecs[i].val));
            @(negedge clk);
            if (vecs[i].flag) expCnt++;
            checkOutput($sformatf("vec%0d true_cnt", i), 32'(trueCnt), 32'(expCnt));
        end

        // Signed MIN/MAX stream issued back-to-back after a clear with nothing retiring.
        trkClr = 1'b1;
        @(negedge clk);
        trkClr = 1'b0;
        checkOutput("clr trk_valid", 32'(trkValid), 32'd0);
        checkOutput("clr true_cnt", 32'(trueCnt), 32'd0);
        streamOp[0] = MAX; streamA[0] = 16'h0005; streamExp[0] = 16'h0005;
        streamOp[1] = MIN; streamA[1] = 16'hFFFD; streamExp[1] = 16'hFFFD;
        streamOp[2] = MAX; streamA[2] = 16'h0009; streamExp[2] = 16'h0009;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                checkOutput($sformatf("stream%0d valid", i-2), 32'(outValid), 32'd1);
                checkOutput($sformatf("stream%0d val", i-2), 32'(cmpVal), 32'(streamExp[i-2]));
            end
            if (i < 3) drive(1'b1, streamOp[i], 1'b1, streamA[i], 16'h0000);
            else       drive(1'b0, NOP, 1'b0, '0, '0);
            @(negedge clk);
        end
        checkOutput("stream drained", 32'(outValid), 32'd0);
        checkOutput("stream trk_valid", 32'(trkValid), 32'd1);
        checkOutput("stream trk_min", 32'(trkMin), 32'h0000FFFD);
        checkOutput("stream trk_max", 32'(trkMax), 32'h00000009);

        // Backpressure: three issued while the consumer stalls for four cycles.
        outReady = 1'b0;
        drive(1'b1, MAX, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        drive(1'b1, MAX, 1'b0, 16'h0011, 16'h0000);
        @(negedge clk);
        drive(1'b1, MAX, 1'b0, 16'h0012, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("stall%0d in_ready", k), 32'(inReady), 32'd0);
            checkOutput($sformatf("stall%0d out_valid", k), 32'(outValid), 32'd1);
            checkOutput($sformatf("stall%0d val", k), 32'(cmpVal), 32'h00000010);
        end
        @(negedge clk);
        outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (outValid) rxQ.push_back(cmpVal);
            @(negedge clk);
            if (k == 0) drive(1'b0, NOP, 1'b0, '0, '0);
        end
        checkOutput("stall rx count", 32'(rxQ.size()), 32'd3);
        for (int k = 0; k < 3 && k < rxQ.size(); k++) begin
            checkOutput($sformatf("stall rx%0d", k), 32'(rxQ[k]), 32'h00000010 + 32'(k));
        end

        // Counter saturation with a long run of EQ hits.
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, EQ, 1'b0, 16'h00AA, 16'h00AA);
            @(negedge clk);
        end
        drive(1'b0, NOP, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        checkOutput("saturated true_cnt", 32'(trueCnt), 32'd255);

        // Clear coincident with a MAX retire loads that value as the first sample.
        applyStimulus(MAX, 1'b0, 16'h0007, 16'h0003, lat);
        checkOutput("clr-max latency", 32'(lat), 32'd2);
        trkClr = 1'b1;
        @(negedge clk);
        trkClr = 1'b0;
        checkOutput("clr-max trk_valid", 32'(trkValid), 32'd1);
        checkOutput("clr-max trk_min", 32'(trkMin), 32'h00000007);
        checkOutput("clr-max trk_max", 32'(trkMax), 32'h00000007);
        checkOutput("clr-max true_cnt", 32'(trueCnt), 32'd0);

        applyStimulus(EQ, 1'b0, 16'h0042, 16'h0042, lat);
        trkClr = 1'b1;
        @(negedge clk);
        trkClr = 1'b0;
        checkOutput("clr-eq true_cnt", 32'(trueCnt), 32'd1);
        checkOutput("clr-eq trk_valid", 32'(trkValid), 32'd0);

        // Reset while two EQ hits are in flight.
        drive(1'b1, EQ, 1'b0, 16'h0001, 16'h0001);
        @(negedge clk);
        drive(1'b1, EQ, 1'b0, 16'h0002, 16'h0002);
        @(negedge clk);
        drive(1'b0, NOP, 1'b0, '0, '0);
        checkOutput("pre-reset out_valid", 32'(outValid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(outValid), 32'd0);
        checkOutput("async reset flag", 32'(cmpFlag), 32'd0);
        checkOutput("async reset code", 32'(cmpCode), 32'd0);
        checkOutput("async reset true_cnt", 32'(trueCnt), 32'd0);
        checkOutput("async reset trk_max", 32'(trkMax), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        leaks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (outValid) leaks++;
        end
        checkOutput("post-reset retires", 32'(leaks), 32'd0);
        checkOutput("post-reset true_cnt", 32'(trueCnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
